// File: rtl/pc_unit_if.sv
// Bundle between decode/branch resolution (master) and the program-counter unit (slave).
// Carries the per-cycle control requests in one direction and the PC/RAS status in the other.
interface pc_unit_if #(
  parameter int PC_W  = 16,
  parameter int BR_W  = 6,
  parameter int JMP_W = 12
);
  logic             clk_en_pi;
  logic             branch_taken_pi;
  logic [BR_W-1:0]  branch_immediate_pi;
  logic             jump_taken_pi;
  logic [JMP_W-1:0] jump_immediate_pi;
  logic             call_pi;
  logic             ret_pi;
  logic             halt_pi;
  logic [PC_W-1:0]  pc_po;
  logic             ras_empty_po;
  logic             ras_full_po;
  logic             ras_err_po;
  logic             halted_po;

  modport master (
    output clk_en_pi, branch_taken_pi, branch_immediate_pi, jump_taken_pi,
           jump_immediate_pi, call_pi, ret_pi, halt_pi,
    input  pc_po, ras_empty_po, ras_full_po, ras_err_po, halted_po
  );

  modport slave (
    input  clk_en_pi, branch_taken_pi, branch_immediate_pi, jump_taken_pi,
           jump_immediate_pi, call_pi, ret_pi, halt_pi,
    output pc_po, ras_empty_po, ras_full_po, ras_err_po, halted_po
  );
endinterface

// File: rtl/pc_unit.sv
// Fetch program counter with PC-relative branch/jump/call/return and a circular return-address stack.
// Optional halt support is compiled in when the macro PC_HALT_EN is defined.
module pc_unit #(
  parameter int PC_W        = 16,
  parameter int INSTR_BYTES = 2,
  parameter int BR_W        = 6,
  parameter int JMP_W       = 12,
  parameter int RAS_DEPTH   = 4,
  parameter int RESET_PC    = 0
) (
  input  logic     clk_pi,
  input  logic     reset_pi,
  pc_unit_if.slave bus
);
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);
  localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    ptr_inc = (p == PTR_W'(RAS_DEPTH - 1)) ? PTR_W'(0) : p + PTR_W'(1);
  endfunction

  function automatic logic [PTR_W-1:0] ptr_dec(input logic [PTR_W-1:0] p);
    ptr_dec = (p == PTR_W'(0)) ? PTR_W'(RAS_DEPTH - 1) : p - PTR_W'(1);
  endfunction

  // The power-up value of the PC is all ones, ahead of any reset.
  logic [PC_W-1:0]  pc_r     = '1;
  logic [CNT_W-1:0] cnt_r    = '0;
  logic [PTR_W-1:0] ptr_r    = '0;
  logic             err_r    = 1'b0;
  logic             halted_r = 1'b0;
  logic             empty_r  = 1'b1;
  logic             full_r   = 1'b0;
  logic [PC_W-1:0]  ras_r [RAS_DEPTH];

  logic [PC_W-1:0]  pc_seq_s;
  logic [PC_W-1:0]  pc_br_s;
  logic [PC_W-1:0]  pc_jmp_s;
  logic [PC_W-1:0]  pc_s;
  logic [CNT_W-1:0] cnt_s;
  logic [PTR_W-1:0] ptr_s;
  logic             err_s;
  logic             halted_s;
  logic             push_s;
  logic             halt_req_s;

`ifdef PC_HALT_EN
  assign halt_req_s = bus.halt_pi;
`else
  assign halt_req_s = 1'b0;
`endif

  assign pc_seq_s = pc_r + PC_W'(INSTR_BYTES);
  assign pc_br_s  = pc_r + {{(PC_W-BR_W){bus.branch_immediate_pi[BR_W-1]}}, bus.branch_immediate_pi};
  assign pc_jmp_s = pc_r + {{(PC_W-JMP_W){bus.jump_immediate_pi[JMP_W-1]}}, bus.jump_immediate_pi};

  // Next-state selection: one prioritised action per enabled, non-halted cycle.
  always_comb begin
    pc_s     = pc_r;
    cnt_s    = cnt_r;
    ptr_s    = ptr_r;
    err_s    = err_r;
    halted_s = halted_r;
    push_s   = 1'b0;
    if (bus.clk_en_pi && !halted_r) begin
      if (halt_req_s) begin
        halted_s = 1'b1;
      end else if (bus.ret_pi) begin
        if (cnt_r != CNT_W'(0)) begin
          pc_s  = ras_r[ptr_dec(ptr_r)];
          ptr_s = ptr_dec(ptr_r);
          cnt_s = cnt_r - CNT_W'(1);
        end else begin
          pc_s  = pc_seq_s;
          err_s = 1'b1;
        end
      end else if (bus.call_pi) begin
        pc_s   = pc_jmp_s;
        push_s = 1'b1;
        ptr_s  = ptr_inc(ptr_r);
        // A full stack overwrites its oldest slot, which is exactly the next write slot.
        if (cnt_r == CNT_W'(RAS_DEPTH)) begin
          err_s = 1'b1;
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end else if (bus.jump_taken_pi) begin
        pc_s = pc_jmp_s;
      end else if (bus.branch_taken_pi) begin
        pc_s = pc_br_s;
      end else begin
        pc_s = pc_seq_s;
      end
    end else begin
      pc_s = pc_r;
    end
  end

  // Architectural state and registered status outputs.
  always_ff @(posedge clk_pi) begin
    if (reset_pi) begin
      pc_r     <= PC_W'(RESET_PC);
      cnt_r    <= CNT_W'(0);
      ptr_r    <= PTR_W'(0);
      err_r    <= 1'b0;
      halted_r <= 1'b0;
      empty_r  <= 1'b1;
      full_r   <= 1'b0;
    end else begin
      pc_r     <= pc_s;
      cnt_r    <= cnt_s;
      ptr_r    <= ptr_s;
      err_r    <= err_s;
      halted_r <= halted_s;
      empty_r  <= (cnt_s == CNT_W'(0));
      full_r   <= (cnt_s == CNT_W'(RAS_DEPTH));
    end
  end

  // Stack storage; contents are don't-care after reset, so no reset term is needed.
  always_ff @(posedge clk_pi) begin
    if (!reset_pi && push_s) begin
      ras_r[ptr_r] <= pc_seq_s;
    end
  end

  assign bus.pc_po        = pc_r;
  assign bus.ras_empty_po = empty_r;
  assign bus.ras_full_po  = full_r;
  assign bus.ras_err_po   = err_r;
  assign bus.halted_po    = halted_r;
endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit for the single-cycle core: holds the fetch PC, advances it by one instruction word per enabled cycle, and applies PC-relative branches, jumps, calls and returns. Adds a return-address stack (RAS) of configurable depth with full/empty status and a sticky error flag. It sits between decode/branch resolution and instruction memory, driving the fetch address.

## Interface

- PC_W, 16: PC width in bits.
- INSTR_BYTES, 2: sequential increment in bytes.
- BR_W, 6: branch offset width, signed, in bytes.
- JMP_W, 12: jump/call offset width, signed, in bytes.
- RAS_DEPTH, 4: RAS entries, ≥1.
- RESET_PC, 0: PC value loaded by reset.

- clk_pi  in  1  clock; all state updates on the rising edge.
- reset_pi  in  1  reset; synchronous, active-high.
- clk_en_pi  in  1  advance enable; when low, all state holds.
- branch_taken_pi  in  1  take conditional branch.
- branch_immediate_pi  in  BR_W  signed branch offset.
- jump_taken_pi  in  1  take unconditional jump.
- jump_immediate_pi  in  JMP_W  signed jump/call offset.
- call_pi  in  1  jump by jump_immediate_pi and push the return address.
- ret_pi  in  1  pop the RAS into the PC.
- halt_pi  in  1  halt request (see Configuration).
- pc_po  out  PC_W  current PC.
- ras_empty_po  out  1  RAS holds 0 entries.
- ras_full_po  out  1  RAS holds RAS_DEPTH entries.
- ras_err_po  out  1  sticky: overflow or underflow has occurred.
- halted_po  out  1  PC frozen by halt.

## Operation

- Power-up, before the first reset, PC = all ones. The testbench and the golden results depend on this value.
- Reset: PC = RESET_PC, RAS count = 0, ras_err_po = 0, halted_po = 0. RAS contents are don't-care.
- If clk_en_pi = 0 or halted_po = 1: everything holds.
- Otherwise, exactly one action per cycle, highest priority first:
  1. ret_pi:
     - RAS non-empty: PC = top entry; count decrements.
     - RAS empty: PC = PC + INSTR_BYTES; ras_err_po set.
  2. call_pi:
     - PC = PC + sext(jump_immediate_pi).
     - Push PC + INSTR_BYTES.
     - RAS full: the oldest entry is discarded (circular overwrite), count stays RAS_DEPTH, ras_err_po set.
  3. jump_taken_pi: PC = PC + sext(jump_immediate_pi).
  4. branch_taken_pi: PC = PC + sext(branch_immediate_pi).
  5. Default: PC = PC + INSTR_BYTES.
- Offsets are relative to the current PC, in bytes, sign-extended to PC_W.
- All PC arithmetic is modulo 2^PC_W. Wrap-around is silent, with no flag.
- Lower-priority requests asserted in the same cycle are ignored, not queued.
- RAS is LIFO:
  - ras_empty_po = (count == 0); ras_full_po = (count == RAS_DEPTH).
  - Count width is clog2(RAS_DEPTH+1).

## Timing

- All outputs are registered. Each new PC is visible on pc_po one cycle after the qualifying edge.
- No combinational path from any input to any output.
- A return target pushed by a call can be popped the very next enabled cycle.
- Reset overrides clk_en_pi and halt, and takes effect on the same edge, including mid-stack or while halted.
- ras_err_po clears only on reset.

## Configuration

- PC_HALT_EN defined:
  - halt_pi = 1 on an enabled cycle sets halted_po on that edge; PC does not advance on that edge.
  - halt has priority over ret/call/jump/branch.
  - Halted state is exited only by reset.
- PC_HALT_EN undefined: halt_pi is ignored and halted_po is tied 0.

## Test plan

- Reset, then 3 enabled idle cycles -> pc_po 0x0000, 0x0002, 0x0004, 0x0006. Before the first reset, pc_po = 0xFFFF.
- At PC 0x0010:
  - branch_immediate_pi = 6'h3C (−4) -> 0x000C.
  - Next cycle, branch and jump together with jump_immediate_pi = 12'h020 -> 0x002C (jump wins).
- Call nesting:
  - At PC 0x0100, call +0x40 -> 0x0140, RAS top = 0x0102.
  - At 0x0140, call −0x20 -> 0x0120.
  - ret -> 0x0142; ret -> 0x0102; ras_empty_po = 1.
- RAS_DEPTH = 4, five calls -> ras_full_po = 1, ras_err_po = 1. Four rets return addresses 5 down to 2. A fifth ret gives PC + 2 and ras_err_po stays 1.
- clk_en_pi low for 3 cycles with call_pi = 1 -> PC and count unchanged. reset_pi during those cycles -> PC = 0, count = 0, ras_err_po = 0.
- PC_HALT_EN defined: halt at 0x0008 -> pc_po stays 0x0008 and halted_po = 1 for 10 cycles despite jumps; reset -> 0x0000, halted_po = 0. PC_HALT_EN undefined: same stimulus -> PC keeps advancing.
